// File: rtl/fft_job_sequencer.sv
// Job controller for the FFT engine: arbitrates the coefficient SRAM between host and engine,
// sequences IDLE/ARM/RUN/DRAIN/DONE. Optional counters under FFT_JOB_SEQUENCER_PERF_EN.
module fft_job_sequencer #(
  parameter int DRAIN_CYCLES = 8,
  parameter int MAX_CYCLES   = 2047
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [2:0]  i_point_config,
  input  logic        i_abort,
  input  logic        i_host_req,
  output logic        o_host_gnt,
  output logic        o_sram_owner,
  output logic        o_working,
  output logic [2:0]  o_point_config,
  output logic [10:0] o_cycle_count,
  input  logic        i_fft_done,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [1:0]  o_err_code,
  output logic [10:0] o_last_run_cycles,
  output logic [15:0] o_run_count
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [10:0] MAX_CNT    = 11'(MAX_CYCLES);
  localparam logic [7:0]  DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);
  localparam logic [2:0]  CFG_MAX    = 3'd4;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CONFIG  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_ABORT   = 2'd3;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v >= MAX_CNT) ? MAX_CNT : v + 11'd1;
  endfunction

  state_t      state_q, state_d;
  logic        host_gnt_q, host_gnt_d;
  logic [2:0]  cfg_q, cfg_d;
  logic [10:0] cycle_cnt_q, cycle_cnt_d;
  logic [7:0]  drain_cnt_q, drain_cnt_d;
  logic        error_q, error_d;
  logic [1:0]  err_code_q, err_code_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      host_gnt_q  <= 1'b0;
      cfg_q       <= 3'd0;
      cycle_cnt_q <= 11'd0;
      drain_cnt_q <= 8'd0;
      error_q     <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      host_gnt_q  <= host_gnt_d;
      cfg_q       <= cfg_d;
      cycle_cnt_q <= cycle_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    cycle_cnt_d = cycle_cnt_q;
    drain_cnt_d = drain_cnt_q;
    error_d     = error_q;
    err_code_d  = err_code_q;
    // Grant is computed from the current state, so it can never overlap engine ownership.
    host_gnt_d  = i_host_req && (state_q == ST_IDLE) && !i_start;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (i_point_config <= CFG_MAX) begin
            cfg_d       = i_point_config;
            error_d     = 1'b0;
            err_code_d  = ERR_NONE;
            cycle_cnt_d = 11'd0;
            state_d     = ST_ARM;
          end else begin
            error_d    = 1'b1;
            err_code_d = ERR_CONFIG;
          end
        end
      end
      ST_ARM: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // done outranks abort, abort outranks timeout; the count freezes on the exit edge
        if (i_fft_done) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end else if (i_abort) begin
          error_d     = 1'b1;
          err_code_d  = ERR_ABORT;
          state_d     = ST_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end else if (cycle_cnt_q == MAX_CNT) begin
          error_d     = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = ST_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end else begin
          cycle_cnt_d = sat_inc(cycle_cnt_q);
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == 8'd0) begin
          state_d = ST_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q - 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_host_gnt     = host_gnt_q;
  assign o_sram_owner   = (state_q == ST_ARM) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign o_working      = (state_q == ST_ARM) || (state_q == ST_RUN);
  assign o_busy         = (state_q != ST_IDLE);
  assign o_done         = (state_q == ST_DONE);
  assign o_point_config = cfg_q;
  assign o_cycle_count  = cycle_cnt_q;
  assign o_error        = error_q;
  assign o_err_code     = err_code_q;

`ifdef FFT_JOB_SEQUENCER_PERF_EN
  logic [10:0] last_run_q, last_run_d;
  logic [15:0] run_cnt_q, run_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_run_q <= 11'd0;
      run_cnt_q  <= 16'd0;
    end else begin
      last_run_q <= last_run_d;
      run_cnt_q  <= run_cnt_d;
    end
  end

  always_comb begin
    last_run_d = last_run_q;
    run_cnt_d  = run_cnt_q;
    if ((state_q == ST_RUN) && (state_d == ST_DRAIN)) begin
      last_run_d = cycle_cnt_q;
    end
    if (state_q == ST_DONE) begin
      run_cnt_d = run_cnt_q + 16'd1;
    end
  end

  assign o_last_run_cycles = last_run_q;
  assign o_run_count       = run_cnt_q;
`else
  assign o_last_run_cycles = 11'd0;
  assign o_run_count       = 16'd0;
`endif

endmodule

// File: tb/tb_fft_job_sequencer.sv
// Randomized bench for fft_job_sequencer against a job-timeline reference model.
module tb_fft_job_sequencer;

  localparam int DRAIN = 8;
  localparam int MAXC  = 2047;

  logic        clk, rst;
  logic        i_start, i_abort, i_host_req, i_fft_done;
  logic [2:0]  i_point_config;
  logic        o_host_gnt, o_sram_owner, o_working, o_busy, o_done, o_error;
  logic [2:0]  o_point_config;
  logic [10:0] o_cycle_count, o_last_run_cycles;
  logic [1:0]  o_err_code;
  logic [15:0] o_run_count;

  fft_job_sequencer #(.DRAIN_CYCLES(DRAIN), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst(rst),
    .i_start(i_start), .i_point_config(i_point_config), .i_abort(i_abort),
    .i_host_req(i_host_req), .o_host_gnt(o_host_gnt), .o_sram_owner(o_sram_owner),
    .o_working(o_working), .o_point_config(o_point_config), .o_cycle_count(o_cycle_count),
    .i_fft_done(i_fft_done), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .o_err_code(o_err_code), .o_last_run_cycles(o_last_run_cycles), .o_run_count(o_run_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: a job is a timeline counted from the accepted start.
  // c=1 is the arm cycle, c=2..X the run cycles (X = exit cycle), then DRAIN
  // cycles, one done cycle, then idle.
  bit         m_active;
  int         m_c, m_x;
  bit         m_err;
  logic [1:0] m_code;
  logic [2:0] m_cfg;
  int         m_last_cnt, m_last_run, m_runs;
  bit         m_gnt;

  bit prev_work, prev_own, prev_done;
  int fall_w;

  task automatic model_reset();
    m_active = 0; m_c = 0; m_x = -1; m_err = 0; m_code = 0; m_cfg = 0;
    m_last_cnt = 0; m_last_run = 0; m_runs = 0; m_gnt = 0;
    prev_work = 0; prev_own = 0; prev_done = 0; fall_w = 0;
  endtask

  task automatic model_edge();
    bit gnt_n;
    gnt_n = i_host_req && !m_active && !i_start;
    if (!m_active) begin
      if (i_start) begin
        if (i_point_config <= 3'd4) begin
          m_active = 1; m_c = 1; m_x = -1;
          m_err = 0; m_code = 0; m_cfg = i_point_config;
        end else begin
          m_err = 1; m_code = 2'd1;
        end
      end
    end else begin
      if (m_x < 0 && m_c >= 2) begin
        if (i_fft_done) m_x = m_c;
        else if (i_abort) begin m_x = m_c; m_err = 1; m_code = 2'd3; end
        else if (m_c - 2 == MAXC) begin m_x = m_c; m_err = 1; m_code = 2'd2; end
        if (m_x >= 0) m_last_run = m_x - 2;
      end
      if (m_x >= 0 && m_c == m_x + DRAIN + 1) begin
        m_active = 0; m_runs = (m_runs + 1) % 65536; m_last_cnt = m_x - 2;
      end else begin
        m_c++;
      end
    end
    m_gnt = gnt_n;
  endtask

  function automatic logic [21:0] dut_vec();
    return {o_host_gnt, o_sram_owner, o_working, o_busy, o_done, o_error,
            o_err_code, o_point_config, o_cycle_count};
  endfunction

  function automatic logic [21:0] exp_vec();
    bit own, work, busy, done;
    int cnt;
    busy = m_active;
    work = m_active && (m_x < 0);
    own  = m_active && ((m_x < 0) || (m_c <= m_x + DRAIN));
    done = m_active && (m_x >= 0) && (m_c == m_x + DRAIN + 1);
    if (!m_active)      cnt = m_last_cnt;
    else if (m_c == 1)  cnt = 0;
    else if (m_x < 0)   cnt = m_c - 2;
    else                cnt = m_x - 2;
    return {m_gnt, own, work, busy, done, m_err, m_code, m_cfg, 11'(cnt)};
  endfunction

  task automatic compare();
    check_eq("outputs", 32'(dut_vec()), 32'(exp_vec()));
    check_eq("handoff", 32'(o_host_gnt & o_sram_owner), 32'd0);
`ifdef FFT_JOB_SEQUENCER_PERF_EN
    check_eq("last_run", 32'(o_last_run_cycles), 32'(m_last_run));
    check_eq("run_count", 32'(o_run_count), 32'(m_runs));
`else
    check_eq("perf_tied", 32'({o_last_run_cycles, o_run_count}), 32'd0);
`endif
    if (prev_work && !o_working) fall_w = cyc;
    if (prev_own && !o_sram_owner) check_eq("drain_len", 32'(cyc - fall_w), 32'(DRAIN));
    if (o_done) check_eq("done_width", 32'(prev_done), 32'd0);
    prev_work = o_working; prev_own = o_sram_owner; prev_done = o_done;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n, input bit hold_req);
    for (int k = 0; k < n; k++) begin
      i_start = 0; i_fft_done = $urandom_range(0, 1); i_abort = $urandom_range(0, 1);
      i_host_req = hold_req ? 1'b1 : 1'($urandom_range(0, 1));
      i_point_config = 3'($urandom_range(0, 7));
      cycle();
    end
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1 check_eq("rst_async", 32'({dut_vec(), o_last_run_cycles != 0, o_run_count != 0}), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    i_start = 0; i_fft_done = 0; i_abort = 0; i_host_req = 0;
    rst = 1'b0;
    compare();
  endtask

  // mode 0: done when the run count hits target; 1: abort there; 2: never done
  task automatic run_job(input logic [2:0] cfg, input int mode, input int target,
                         input bit hold_req, input bit rst_drain);
    i_start = 1; i_point_config = cfg; i_fft_done = 0; i_abort = 0;
    i_host_req = hold_req ? 1'b1 : 1'($urandom_range(0, 1));
    cycle();
    for (int k = 0; k < 5000 && m_active; k++) begin
      bit in_run;
      int rc;
      in_run = (m_c >= 2) && (m_x < 0);
      rc = m_c - 2;
      if (rst_drain && m_x >= 0 && m_c == m_x + 3) begin
        async_reset();
        break;
      end
      i_host_req = hold_req ? 1'b1 : 1'($urandom_range(0, 1));
      if (hold_req) check_eq("gnt_during_job", 32'(o_host_gnt), 32'd0);
      i_point_config = 3'($urandom_range(0, 7));
      i_start = ($urandom_range(0, 3) == 0);
      if (in_run) begin
        i_fft_done = (mode == 0) && (rc == target);
        i_abort    = (mode == 1) && (rc == target);
      end else begin
        i_fft_done = $urandom_range(0, 1);
        i_abort    = $urandom_range(0, 1);
      end
      cycle();
    end
    i_start = 0; i_fft_done = 0; i_abort = 0;
    check_eq("job_end_busy", 32'(o_busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; i_start = 0; i_abort = 0; i_host_req = 0; i_fft_done = 0; i_point_config = 0;
    model_reset();
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check_eq("reset_state", 32'({dut_vec(), o_last_run_cycles != 0, o_run_count != 0}), 32'd0);
    rst = 0;

    // host access from idle
    i_host_req = 1;
    cycle();
    cycle();
    check_eq("idle_gnt", 32'({o_host_gnt, o_sram_owner, o_busy}), 32'b100);

    // nominal job: done after 100 run cycles
    run_job(3'd3, 0, 100, 0, 0);
    check_eq("nominal_count", 32'(o_cycle_count), 32'd100);
    check_eq("nominal_err", 32'({o_error, o_err_code}), 32'd0);
    idle(3, 0);

    // illegal config never starts the engine
    i_start = 1; i_point_config = 3'd6; i_host_req = 0;
    cycle();
    i_start = 0;
    check_eq("illegal_err", 32'({o_error, o_err_code, o_working, o_busy}), 32'b10100);
    idle(3, 0);

    // timeout, then a legal start clears the sticky error
    run_job(3'd2, 2, 0, 0, 0);
    check_eq("timeout_count", 32'(o_cycle_count), 32'(MAXC));
    check_eq("timeout_err", 32'({o_error, o_err_code}), 32'b110);
    i_start = 1; i_point_config = 3'd1;
    cycle();
    i_start = 0;
    check_eq("err_cleared", 32'({o_error, o_err_code, o_working}), 32'b0001);
    for (int k = 0; k < 5000 && m_active; k++) begin
      i_fft_done = (m_c == 12); i_abort = 0;
      cycle();
    end
    i_fft_done = 0;
    idle(2, 0);

    // abort with host request held throughout
    run_job(3'd4, 1, 20, 1, 0);
    check_eq("abort_err", 32'({o_error, o_err_code}), 32'b111);
    idle(3, 1);
    check_eq("abort_gnt_after", 32'(o_host_gnt), 32'd1);

    // reset mid-drain, then a fresh job
    run_job(3'd0, 0, 30, 0, 1);
    run_job(3'd2, 0, 15, 0, 0);
`ifdef FFT_JOB_SEQUENCER_PERF_EN
    check_eq("perf_runs_one", 32'(o_run_count), 32'd1);
`endif
    idle(2, 0);

    // randomized jobs
    for (int j = 0; j < 16; j++) begin
      run_job(3'($urandom_range(0, 7)), $urandom_range(0, 1), $urandom_range(0, 400), 0, 0);
      idle($urandom_range(1, 4), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
